// File: rtl/stall_ctrl.sv
// Hazard-detection stall controller: load-use interlock, plus a mult/div busy tracker
// that is compiled in only when STALL_CTRL_MDU_EN is defined.
module stall_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [4:0]  rs_d,
    input  logic [4:0]  rt_d,
    input  logic        use_rs_d,
    input  logic        use_rt_d,
    input  logic        ex_load,
    input  logic [4:0]  ex_rd,
    input  logic        md_use_d,
    input  logic        md_start,
    input  logic        md_is_div,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        idex_bubble,
    output logic        md_busy,
    output logic [3:0]  md_count,
    output logic [15:0] stall_total
);

    logic        w_lu_hz;
    logic        w_md_hz;
    logic        w_stall;
    logic [15:0] r_stall_total;

    // Register $0 is never a real producer, so a load into it cannot create a hazard.
    assign w_lu_hz = ex_load && (ex_rd != 5'd0) &&
                     ((use_rs_d && (rs_d == ex_rd)) || (use_rt_d && (rt_d == ex_rd)));

`ifdef STALL_CTRL_MDU_EN
    localparam logic [3:0] LP_MULT = 4'(MULT_CYCLES);
    localparam logic [3:0] LP_DIV  = 4'(DIV_CYCLES);

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t     r_state;
    logic [3:0] r_md_count;
    logic       r_md_busy;
    logic [3:0] w_md_lat;

    assign w_md_lat = md_is_div ? LP_DIV : LP_MULT;

    // A new start always wins, restarting the countdown with its own latency.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_md_count <= 4'd0;
            r_md_busy  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (md_start) begin
                        r_state    <= S_BUSY;
                        r_md_count <= w_md_lat;
                        r_md_busy  <= 1'b1;
                    end
                end
                S_BUSY: begin
                    if (md_start) begin
                        r_md_count <= w_md_lat;
                        r_md_busy  <= 1'b1;
                    end else if (r_md_count <= 4'd1) begin
                        r_state    <= S_IDLE;
                        r_md_count <= 4'd0;
                        r_md_busy  <= 1'b0;
                    end else begin
                        r_md_count <= r_md_count - 4'd1;
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_md_count <= 4'd0;
                    r_md_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign w_md_hz  = md_use_d && (r_md_busy || md_start);
    assign md_busy  = r_md_busy;
    assign md_count = r_md_count;
`else
    logic w_unused_md;

    assign w_unused_md = ^{md_use_d, md_start, md_is_div};
    assign w_md_hz     = 1'b0;
    assign md_busy     = 1'b0;
    assign md_count    = 4'd0;
`endif

    // Both hazards collapse into a single stall; they never stack bubbles.
    assign w_stall = w_lu_hz || w_md_hz;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stall_total <= 16'd0;
        end else if (w_stall && (r_stall_total != 16'hFFFF)) begin
            r_stall_total <= r_stall_total + 16'd1;
        end
    end

    // The pipeline is frozen with a bubble in ID/EX for as long as reset is held.
    assign pc_en       = reset_n && !w_stall;
    assign ifid_en     = reset_n && !w_stall;
    assign idex_bubble = !reset_n || w_stall;
    assign stall_total = r_stall_total;

endmodule

// File: tb/tb_stall_ctrl.sv
// Scoreboard bench for stall_ctrl: a cycle model pushes expected outputs, which are popped
// and compared against the DUT mid-cycle. Follows STALL_CTRL_MDU_EN like the design.
`timescale 1ns/1ps
module tb_stall_ctrl;
    localparam int MULT_CYCLES = 5;
    localparam int DIV_CYCLES  = 10;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [4:0]  rs_d = '0, rt_d = '0, ex_rd = '0;
    logic        use_rs_d = 1'b0, use_rt_d = 1'b0, ex_load = 1'b0;
    logic        md_use_d = 1'b0, md_start = 1'b0, md_is_div = 1'b0;
    logic        pc_en, ifid_en, idex_bubble, md_busy;
    logic [3:0]  md_count;
    logic [15:0] stall_total;

    always #5 clk = ~clk;

    stall_ctrl #(.MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES)) dut (
        .clk(clk), .reset_n(reset_n),
        .rs_d(rs_d), .rt_d(rt_d), .use_rs_d(use_rs_d), .use_rt_d(use_rt_d),
        .ex_load(ex_load), .ex_rd(ex_rd),
        .md_use_d(md_use_d), .md_start(md_start), .md_is_div(md_is_div),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_bubble(idex_bubble),
        .md_busy(md_busy), .md_count(md_count), .stall_total(stall_total)
    );

    typedef struct {
        logic        pc_en;
        logic        ifid_en;
        logic        bubble;
        logic        busy;
        logic [3:0]  count;
        logic [15:0] total;
    } exp_t;

    exp_t        exp_q[$];
    int          n_assert = 0;
    int          n_fail   = 0;
    bit          verbose  = 1'b1;
    logic [3:0]  m_count  = 4'd0;
    logic [15:0] m_total  = 16'd0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic cycle(input string tag, input logic rst,
                         input logic [4:0] rs, input logic [4:0] rt,
                         input logic urs, input logic urt,
                         input logic ld, input logic [4:0] rd,
                         input logic mu, input logic ms, input logic mdiv);
        exp_t e;
        exp_t o;
        logic lu, md, st;
        @(negedge clk);
        reset_n = rst; rs_d = rs; rt_d = rt; use_rs_d = urs; use_rt_d = urt;
        ex_load = ld; ex_rd = rd; md_use_d = mu; md_start = ms; md_is_div = mdiv;
        if (!rst) begin
            m_count = 4'd0;
            m_total = 16'd0;
        end
        lu = ld && (rd != 5'd0) && ((urs && (rs == rd)) || (urt && (rt == rd)));
`ifdef STALL_CTRL_MDU_EN
        md = mu && ((m_count != 4'd0) || ms);
`else
        md = 1'b0;
`endif
        st        = rst && (lu || md);
        e.pc_en   = rst && !st;
        e.ifid_en = rst && !st;
        e.bubble  = !rst || st;
        e.busy    = (m_count != 4'd0);
        e.count   = m_count;
        e.total   = m_total;
        exp_q.push_back(e);
        #2;
        o = exp_q.pop_front();
        check_val({tag, ".pc_en"},       32'(pc_en),       32'(o.pc_en));
        check_val({tag, ".ifid_en"},     32'(ifid_en),     32'(o.ifid_en));
        check_val({tag, ".idex_bubble"}, 32'(idex_bubble), 32'(o.bubble));
        check_val({tag, ".md_busy"},     32'(md_busy),     32'(o.busy));
        check_val({tag, ".md_count"},    32'(md_count),    32'(o.count));
        check_val({tag, ".stall_total"}, 32'(stall_total), 32'(o.total));
        if (verbose)
            $display("%-10s rst_n=%b lu=%b md_use=%b start=%b div=%b -> pc_en=%b bubble=%b busy=%b count=%0d total=%0d",
                     tag, rst, lu, mu, ms, mdiv, pc_en, idex_bubble, md_busy, md_count, stall_total);
        @(posedge clk);
        if (rst) begin
            if (st && (m_total != 16'hFFFF)) m_total = m_total + 16'd1;
`ifdef STALL_CTRL_MDU_EN
            if (ms)                   m_count = mdiv ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
            else if (m_count != 4'd0) m_count = m_count - 4'd1;
`endif
        end
    endtask

    task automatic idle(input string tag);
        cycle(tag, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic md_op(input string tag, input logic mu, input logic ms, input logic mdiv);
        cycle(tag, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, mu, ms, mdiv);
    endtask

    initial begin
        cycle("reset", 1'b0, 5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 5'd8, 1'b1, 1'b1, 1'b1);
        cycle("reset", 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        idle("post_rst");

        // Load-use cases: real hazard on rs and rt, $0 destination, no load, unused operand.
        cycle("lu_rs",    1'b1, 5'd8, 5'd3, 1'b1, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0);
        cycle("lu_rt",    1'b1, 5'd1, 5'd9, 1'b1, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0);
        cycle("lu_r0",    1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        cycle("no_load",  1'b1, 5'd8, 5'd8, 1'b1, 1'b1, 1'b0, 5'd8, 1'b0, 1'b0, 1'b0);
        cycle("unused",   1'b1, 5'd8, 5'd8, 1'b0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0);
        idle("idle");

        // Divide with a dependent MFHI/MFLO waiting in ID.
        md_op("div_start", 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 12; i++) md_op("div_wait", 1'b1, 1'b0, 1'b0);

        // Multiply, then a divide two cycles later restarts the countdown.
        md_op("mul_start", 1'b0, 1'b1, 1'b0);
        md_op("mul_run",   1'b0, 1'b0, 1'b0);
        md_op("div_rest",  1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 11; i++) md_op("rest_wait", 1'b1, 1'b0, 1'b0);

        // Load-use and mult/div hazard in the same cycles.
        md_op("mul_start", 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++)
            cycle("both_hz", 1'b1, 5'd4, 5'd0, 1'b1, 1'b0, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) md_op("mul_drain", 1'b0, 1'b0, 1'b0);

        // Reset asserted while busy at count 3 aborts the operation at once.
        md_op("mul_start", 1'b0, 1'b1, 1'b0);
        md_op("mul_run",   1'b0, 1'b0, 1'b0);
        md_op("mul_run",   1'b0, 1'b0, 1'b0);
        cycle("rst_busy",  1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
        cycle("rst_hold",  1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
        md_op("post_rst",  1'b1, 1'b0, 1'b0);

        // Start without a dependent instruction: counter runs, no stall.
        md_op("mul_quiet", 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) md_op("mul_quiet", 1'b0, 1'b0, 1'b0);

        // Saturate the stall counter, then confirm it holds.
        verbose = 1'b0;
        for (int i = 0; i < 65536; i++)
            cycle("sat", 1'b1, 5'd7, 5'd0, 1'b1, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0);
        verbose = 1'b1;
        for (int i = 0; i < 3; i++)
            cycle("sat_hold", 1'b1, 5'd7, 5'd0, 1'b1, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0);
        idle("sat_idle");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/stall_ctrl.md
STALL_CTRL -- requirements
Module: stall_ctrl

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5, meaning EX-stage occupancy of MULT/MULTU in cycles (1..15).
REQ-002 SHALL have parameter DIV_CYCLES, default 10, meaning EX-stage occupancy of DIV/DIVU in cycles (1..15).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports rs_d, rt_d  input  5 each  source register numbers of the instruction in ID.
REQ-006 SHALL have ports use_rs_d, use_rt_d  input  1 each  ID instruction reads rs/rt in ID or EX.
REQ-007 SHALL have ports ex_load  input  1 and ex_rd  input  5  EX holds a load writing ex_rd.
REQ-008 SHALL have port md_use_d  input  1  ID holds MULT/DIV/MFHI/MFLO/MTHI/MTLO.
REQ-009 SHALL have ports md_start  input  1 and md_is_div  input  1  EX starts mult (0) or div (1) this cycle.
REQ-010 SHALL have outputs pc_en  1  and ifid_en  1  write enables for PC and IF/ID.
REQ-011 SHALL have output idex_bubble  1  forces ID/EX to load the all-zero NOP word.
REQ-012 SHALL have outputs md_busy  1  and md_count  4  remaining mult/div cycles.
REQ-013 SHALL have output stall_total  16  saturating count of stalled cycles.

Function
REQ-014 lu_hz SHALL be ex_load and ex_rd!=0 and ((use_rs_d and rs_d==ex_rd) or (use_rt_d and rt_d==ex_rd)).
REQ-015 md_hz SHALL be md_use_d and (md_busy or md_start).
REQ-016 stall SHALL be lu_hz or md_hz, combinational, same cycle; pc_en=ifid_en=!stall; idex_bubble=stall.
REQ-017 Simultaneous lu_hz and md_hz SHALL produce one stall cycle per clock, no extra bubble.
REQ-018 FSM states IDLE, BUSY; IDLE->BUSY on md_start; BUSY->IDLE when md_count reaches 0.
REQ-019 On md_start, md_count SHALL load DIV_CYCLES if md_is_div else MULT_CYCLES, visible next cycle.
REQ-020 In BUSY without md_start, md_count SHALL decrement by 1 per cycle; md_busy = (md_count!=0).
REQ-021 md_start while BUSY SHALL restart md_count with the new latency (no queueing).
REQ-022 With MULT_CYCLES=5, md_busy SHALL be high exactly 5 cycles after the md_start edge.
REQ-023 stall_total SHALL increment each cycle stall=1 and hold at 16'hFFFF (no wrap).

Reset
REQ-024 While reset_n=0: state IDLE, md_count=0, md_busy=0, stall_total=0, pc_en=0, ifid_en=0, idex_bubble=1.
REQ-025 reset_n asserted mid-operation (BUSY) SHALL abort immediately to IDLE with md_count=0.
REQ-026 First edge after reset_n rises SHALL see normal operation; no stall with no hazard.

Configuration
REQ-027 Macro STALL_CTRL_MDU_EN defined: REQ-015, REQ-018..REQ-022 implemented as above.
REQ-028 Macro STALL_CTRL_MDU_EN undefined: FSM and counter absent, md_hz=0, md_busy=0, md_count=0, md_* inputs ignored.

Verification
REQ-029 ex_load=1, ex_rd=8, rs_d=8, use_rs_d=1 -> same cycle pc_en=0, ifid_en=0, idex_bubble=1; stall_total +1.
REQ-030 ex_load=1, ex_rd=0, rt_d=0, use_rt_d=1 -> no stall, pc_en=1.
REQ-031 md_start=1, md_is_div=1, then md_use_d=1 held -> md_count 10,9..1,0; stall for the md_start cycle plus 10 cycles, released when md_count=0.
REQ-032 md_start mult, md_start div 2 cycles later -> md_count reloads 10, busy until it reaches 0.
REQ-033 reset_n pulsed low at md_count=3 -> md_busy=0, md_count=0 immediately; outputs per REQ-024.
REQ-034 Force 65536 stall cycles -> stall_total=16'hFFFF and holds; rebuild without STALL_CTRL_MDU_EN, md_start=1 -> md_busy stays 0.
